filt_ppd: RTL and testbench

Polyphase decimation FIR filter: the receive-side counterpart of the polyphase interpolator. It accepts one input sample per enabled clock, and its input commutator steps a phase counter across the decimation factor. It emits one full-precision filtered output every `gp_decimation_factor` accepted samples, flagged by a single-cycle valid strobe. It runs entirely in the input-sample clock domain and feeds downstream low-rate processing.

---
 rtl/filt_ppd.sv | 103 ++++++++++
 tb/tb_filt_ppd.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/filt_ppd.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | filt_ppd : polyphase decimating FIR, one full-precision output per M inputs |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module filt_ppd #(
  parameter int gp_idata_width       = 8,
  parameter int gp_decimation_factor = 4,
  parameter int gp_coeff_length      = 8,
  parameter int gp_coeff_width       = 16,
  parameter logic [gp_coeff_length*gp_coeff_width-1:0] gp_coeff = '0,
  parameter int gp_comm_phase        = 0,
  parameter int gp_odata_width       = 28
) (
  input  logic                             i_clk,
  input  logic                             i_rst_an,
  input  logic                             i_ena,
  input  logic                             i_sync,
  input  logic signed [gp_idata_width-1:0] i_data,
  output logic signed [gp_odata_width-1:0] o_data,
  output logic                             o_valid
);

  localparam int IW   = gp_idata_width;
  localparam int CW   = gp_coeff_width;
  localparam int OW   = gp_odata_width;
  localparam int L    = gp_coeff_length;
  localparam int PW   = IW + CW;
  localparam int DL   = (L > 1) ? L - 1 : 1;
  localparam int CNTW = (gp_decimation_factor > 1) ? $clog2(gp_decimation_factor) : 1;
  localparam logic [CNTW-1:0] PHASE_LAST = CNTW'(gp_decimation_factor - 1);
  localparam logic [CNTW-1:0] PHASE_OUT  = CNTW'(gp_comm_phase);

  logic        [CNTW-1:0] phase_q, phase_d;
  logic signed [IW-1:0]   dly_q [0:DL-1];
  logic signed [IW-1:0]   dly_d [0:DL-1];
  logic signed [OW-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;

  logic signed [IW-1:0]   win [0:L-1];
  logic signed [CW-1:0]   coef;
  logic signed [PW-1:0]   prod;
  logic signed [OW-1:0]   acc;

  // Window is the incoming sample plus the L-1 previous ones, newest first.
  always_comb begin
    win[0] = i_data;
    for (int k = 1; k < L; k++) begin
      win[k] = dly_q[k-1];
    end
    acc  = '0;
    coef = '0;
    prod = '0;
    for (int k = 0; k < L; k++) begin
      coef = gp_coeff[k*CW +: CW];
      prod = win[k] * coef;
      acc  = acc + OW'(prod);
    end
  end

  always_comb begin
    phase_d = phase_q;
    dly_d   = dly_q;
    data_d  = data_q;
    valid_d = 1'b0;
    if (i_sync) begin
      phase_d = '0;
      for (int k = 0; k < DL; k++) begin
        dly_d[k] = '0;
      end
      data_d = '0;
    end else if (i_ena) begin
      phase_d  = (phase_q == PHASE_LAST) ? '0 : phase_q + CNTW'(1);
      dly_d[0] = i_data;
      for (int k = 1; k < DL; k++) begin
        dly_d[k] = dly_q[k-1];
      end
      if (phase_q == PHASE_OUT) begin
        valid_d = 1'b1;
        data_d  = acc;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_an) begin
    if (!i_rst_an) begin
      phase_q <= '0;
      dly_q   <= '{default: '0};
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      dly_q   <= dly_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign o_data  = data_q;
  assign o_valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_filt_ppd.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_filt_ppd : five filt_ppd configurations against a sample-history model   |
// | Revision    : 1.0                                                           |
// +----------------------------------------------------------------------------+
module tb_filt_ppd;

  localparam logic [127:0] H_A = {16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
  localparam logic [127:0] H_C = {8{16'h8000}};
  localparam logic [111:0] H_D = {16'h1000, 16'hFFFB, 16'h0005, 16'h8000,
                                  16'h7FFF, 16'hFF00, 16'h0123};
  localparam logic [47:0]  H_E = {16'hFFFE, 16'h0003, 16'h0001};

  int mm [5] = '{4, 4, 4, 3, 1};
  int ll [5] = '{8, 8, 8, 7, 3};
  int pp [5] = '{0, 3, 0, 1, 0};

  logic clk = 1'b0;
  logic rst_n, ena, sync;
  logic signed [7:0]  din;
  logic        [4:0]  ov;
  logic signed [27:0] od [5];

  always #5 clk = ~clk;

  filt_ppd #(.gp_decimation_factor(4), .gp_coeff_length(8), .gp_coeff(H_A), .gp_comm_phase(0))
    u_a (.i_clk(clk), .i_rst_an(rst_n), .i_ena(ena), .i_sync(sync), .i_data(din),
         .o_data(od[0]), .o_valid(ov[0]));
  filt_ppd #(.gp_decimation_factor(4), .gp_coeff_length(8), .gp_coeff(H_A), .gp_comm_phase(3))
    u_b (.i_clk(clk), .i_rst_an(rst_n), .i_ena(ena), .i_sync(sync), .i_data(din),
         .o_data(od[1]), .o_valid(ov[1]));
  filt_ppd #(.gp_decimation_factor(4), .gp_coeff_length(8), .gp_coeff(H_C), .gp_comm_phase(0))
    u_c (.i_clk(clk), .i_rst_an(rst_n), .i_ena(ena), .i_sync(sync), .i_data(din),
         .o_data(od[2]), .o_valid(ov[2]));
  filt_ppd #(.gp_decimation_factor(3), .gp_coeff_length(7), .gp_coeff(H_D), .gp_comm_phase(1))
    u_d (.i_clk(clk), .i_rst_an(rst_n), .i_ena(ena), .i_sync(sync), .i_data(din),
         .o_data(od[3]), .o_valid(ov[3]));
  filt_ppd #(.gp_decimation_factor(1), .gp_coeff_length(3), .gp_coeff(H_E), .gp_comm_phase(0))
    u_e (.i_clk(clk), .i_rst_an(rst_n), .i_ena(ena), .i_sync(sync), .i_data(din),
         .o_data(od[4]), .o_valid(ov[4]));

  int     n_vec = 0;
  int     n_err = 0;
  bit     chk_en = 1'b0;
  int     hist [0:4095];
  int     cnt = 0;
  longint exp_d [5] = '{default: 0};
  bit     exp_v [5] = '{default: 1'b0};
  longint obs [5][$];

  function automatic longint h_of(int i, int k);
    logic signed [15:0] t;
    case (i)
      0, 1:    t = H_A[k*16 +: 16];
      2:       t = H_C[k*16 +: 16];
      3:       t = H_D[k*16 +: 16];
      default: t = H_E[k*16 +: 16];
    endcase
    return longint'(t);
  endfunction

  // y = sum_k h[k] * x[j-k], with samples before the last clear taken as zero
  function automatic longint fir(int i, int j);
    longint s = 0;
    for (int k = 0; k < ll[i]; k++) begin
      if (j - k >= 0) s += h_of(i, k) * longint'(hist[j-k]);
    end
    return s;
  endfunction

  task automatic chk(string nm, longint act, longint expv);
    n_vec++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
    end
  endtask

  task automatic model_clear();
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      exp_v[i] = 1'b0;
      exp_d[i] = 0;
    end
  endtask

  task automatic model_step(bit e, bit s, int d);
    logic signed [7:0] t;
    t = d[7:0];
    if (!rst_n) return;
    if (s) begin
      model_clear();
    end else if (e) begin
      hist[cnt] = int'(t);
      for (int i = 0; i < 5; i++) begin
        exp_v[i] = ((cnt % mm[i]) == pp[i]);
        if (exp_v[i]) exp_d[i] = fir(i, cnt);
      end
      if (cnt < 4095) cnt++;
    end else begin
      for (int i = 0; i < 5; i++) exp_v[i] = 1'b0;
    end
  endtask

  task automatic cyc(bit e, bit s, int d);
    @(negedge clk);
    ena  = e;
    sync = s;
    din  = d[7:0];
    @(posedge clk);
    model_step(e, s, d);
  endtask

  task automatic clear_obs();
    for (int i = 0; i < 5; i++) obs[i].delete();
  endtask

  task automatic check_head(string nm, int i, int idx, longint v);
    if (obs[i].size() > idx) begin
      chk($sformatf("%s[%0d][%0d]", nm, i, idx), obs[i][idx], v);
    end else begin
      n_vec++;
      n_err++;
      $display("FAIL %s[%0d][%0d]: got no strobe, expected %0d", nm, i, idx, v);
    end
  endtask

  task automatic run_impulse(bit gaps);
    cyc(1'b0, 1'b1, 0);
    clear_obs();
    for (int j = 0; j < 13; j++) begin
      if (gaps) repeat ($urandom_range(0, 5)) cyc(1'b0, 1'b0, 0);
      cyc(1'b1, 1'b0, (j == 0) ? 1 : 0);
    end
    repeat (3) cyc(1'b0, 1'b0, 0);
  endtask

  longint imp_exp [5][3] = '{'{1, 5, 0}, '{4, 8, 0}, '{-32768, -32768, 0},
                             '{-256, 5, 0}, '{1, 3, -2}};

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int i = 0; i < 5; i++) begin
          chk($sformatf("valid[%0d] t=%0t", i, $time), longint'(ov[i]), longint'(exp_v[i]));
          chk($sformatf("data[%0d] t=%0t", i, $time), longint'(od[i]), exp_d[i]);
          if (ov[i]) obs[i].push_back(longint'(od[i]));
        end
      end
    end
  end

  initial begin
    rst_n = 1'b1;
    ena   = 1'b0;
    sync  = 1'b0;
    din   = '0;
    #1 rst_n = 1'b0;
    #2;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("reset_valid[%0d]", i), longint'(ov[i]), 0);
      chk($sformatf("reset_data[%0d]", i), longint'(od[i]), 0);
    end
    chk_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    run_impulse(1'b0);
    for (int i = 0; i < 5; i++)
      for (int n = 0; n < 3; n++) check_head("impulse", i, n, imp_exp[i][n]);

    run_impulse(1'b1);
    for (int i = 0; i < 5; i++)
      for (int n = 0; n < 3; n++) check_head("gapped", i, n, imp_exp[i][n]);

    cyc(1'b0, 1'b1, 0);
    repeat (20) cyc(1'b1, 1'b0, -128);
    cyc(1'b0, 1'b0, 0);
    chk("worst_case", longint'(od[2]), 64'sd33554432);
    chk("worst_case_ramp", longint'(od[0]), -4608);

    cyc(1'b0, 1'b1, 0);
    cyc(1'b1, 1'b0, 5);
    cyc(1'b1, 1'b0, -3);
    cyc(1'b1, 1'b0, 9);
    cyc(1'b1, 1'b1, 77);
    @(negedge clk);
    #1 chk("sync_no_strobe", longint'(ov), 0);
    clear_obs();
    cyc(1'b1, 1'b0, 1);
    repeat (8) cyc(1'b1, 1'b0, 0);
    cyc(1'b0, 1'b0, 0);
    check_head("after_sync", 0, 0, 1);
    check_head("after_sync", 1, 0, 4);
    check_head("after_sync", 3, 0, -256);

    repeat (50) cyc(($urandom_range(0, 3) != 0), 1'b0, int'($urandom));
    #2 rst_n = 1'b0;
    model_clear();
    #1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("async_reset_valid[%0d]", i), longint'(ov[i]), 0);
      chk($sformatf("async_reset_data[%0d]", i), longint'(od[i]), 0);
    end
    repeat (3) cyc(1'b1, 1'b0, 55);
    @(negedge clk);
    rst_n = 1'b1;
    ena   = 1'b0;
    repeat (1000) cyc(($urandom_range(0, 3) != 0), 1'b0, int'($urandom));
    repeat (2) cyc(1'b0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
